// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory stream reader: FSM state encoding and
// output FIFO depth.
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/mem_stream_fifo.sv
// Small synchronous FIFO buffering memory read data ahead of the stream port.
// DEPTH must be a power of two; pushes when full and pops when empty are ignored.
module mem_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == FULL_LEVEL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: fetches count words from a 1-cycle-latency memory starting at
// base and streams them out via valid/ready. MEM_STREAM_READER_BITREV_EN adds
// a bitrev input selecting bit-reversed burst addressing.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   base,
  input  logic [$clog2(DEPTH):0]     count,
`ifdef MEM_STREAM_READER_BITREV_EN
  input  logic                       bitrev,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   rdaddress,
  output logic                       rden,
  input  logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FIFO_LIMIT = LW'(FIFO_DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW:0]     remain_q, remain_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            inflight_q, inflight_d;
  logic            done_q, done_d;
`ifdef MEM_STREAM_READER_BITREV_EN
  logic            bitrev_q, bitrev_d;
`endif

  logic [LW-1:0]   fifo_level;
  logic [LW-1:0]   occupancy;
  logic            fifo_full, fifo_empty;
  logic            pop, drain_exit;
  logic [AW-1:0]   idx_next, addr_off;

  mem_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (q),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign occupancy  = fifo_level + LW'(inflight_q);
  assign drain_exit = (state_q == DRAIN) && !inflight_q && (fifo_level == LW'(1)) && pop;
  assign idx_next   = idx_q + 1'b1;
  assign rdaddress  = addr_q;
  assign done       = done_q;

`ifdef MEM_STREAM_READER_BITREV_EN
  function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] v);
    for (int unsigned i = 0; i < AW; i++) begin
      bit_reverse[i] = v[AW-1-i];
    end
  endfunction

  assign addr_off = bitrev_q ? bit_reverse(idx_next) : idx_next;
`else
  assign addr_off = idx_next;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && count != '0) state_d = RUN;
      RUN:     if (rden && remain_q == (AW+1)'(1)) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads are throttled so every issued word is guaranteed a FIFO slot.
  always_comb begin
    busy = (state_q != IDLE);
    rden = (state_q == RUN) && (occupancy < FIFO_LIMIT) && !fifo_full;
  end

  // rdaddress is pre-computed for the next read, so it only moves after a read.
  always_comb begin
    base_d     = base_q;
    remain_d   = remain_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    inflight_d = rden;
    done_d     = 1'b0;
`ifdef MEM_STREAM_READER_BITREV_EN
    bitrev_d   = bitrev_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            base_d   = base;
            remain_d = count;
            idx_d    = '0;
            addr_d   = base;
`ifdef MEM_STREAM_READER_BITREV_EN
            bitrev_d = bitrev;
`endif
          end
        end
      end
      RUN: begin
        if (rden) begin
          remain_d = remain_q - 1'b1;
          idx_d    = idx_next;
          addr_d   = base_q + addr_off;
        end
      end
      DRAIN: begin
        done_d = drain_exit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      remain_q   <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_STREAM_READER_BITREV_EN
      bitrev_q   <= 1'b0;
`endif
    end else begin
      base_q     <= base_d;
      remain_q   <= remain_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
`ifdef MEM_STREAM_READER_BITREV_EN
      bitrev_q   <= bitrev_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: random bursts against a queue model
// of the expected address and data sequences.
module tb_mem_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic [AW-1:0]    base;
  logic [AW:0]      count;
  logic             busy, done, rden, out_valid, out_ready;
  logic [AW-1:0]    rdaddress;
  logic [WIDTH-1:0] q, out_data;
`ifdef MEM_STREAM_READER_BITREV_EN
  logic             bitrev;
`endif

  always #5 clock = ~clock;

  mem_stream_reader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base      (base),
    .count     (count),
`ifdef MEM_STREAM_READER_BITREV_EN
    .bitrev    (bitrev),
`endif
    .busy      (busy),
    .done      (done),
    .rdaddress (rdaddress),
    .rden      (rden),
    .q         (q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) if (rden) q <= mem[rdaddress];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  int issued, popped, first_rden, first_valid, done_cyc;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] data_prev;
  logic [AW-1:0]    exp_addr[$];
  logic [WIDTH-1:0] exp_data[$];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rev_bits(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) if (((k >> i) & 1) != 0) r += 1 << (AW - 1 - i);
    return r;
  endfunction

  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (rden) begin
        issued++;
        if (first_rden < 0) first_rden = cyc;
        if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
        else check("rdaddress", int'(rdaddress), int'(exp_addr.pop_front()));
        check("outstanding_le4", int'(issued - popped <= 4), 1);
      end
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(data_prev));
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        popped++;
        if (exp_data.size() == 0) check("unexpected_word", 1, 0);
        else check("out_data", int'(out_data), int'(exp_data.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      if (done && done_cyc < 0) done_cyc = cyc;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic begin_burst(input int b, input int n, input int br, output int c0);
    int a;
    @(posedge clock);
    #1;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    for (int k = 0; k < n; k++) begin
      a = (b + ((br != 0) ? rev_bits(k) : k)) % DEPTH;
      exp_addr.push_back(AW'(a));
      exp_data.push_back(mem[a]);
    end
    issued = 0; popped = 0; first_rden = -1; first_valid = -1; done_cyc = -1;
    c0 = cyc;
    start = 1'b1;
    base  = AW'(b);
    count = (AW+1)'(n);
`ifdef MEM_STREAM_READER_BITREV_EN
    bitrev = 1'(br);
`endif
    @(posedge clock);
    #1;
    // A second start while busy must be ignored.
    start = (n > 0);
    base  = AW'($urandom);
    count = (AW+1)'($urandom_range(1, DEPTH));
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input int b, input int n, input int br, input bit timing, input int hold);
    int c0;
    int w = 0;
    int saved = ready_mode;
    if (hold > 0) ready_mode = 2;
    begin_burst(b, n, br, c0);
    while (done_cyc < 0 && w < 3000) begin
      @(negedge clock);
      w++;
      if (hold > 0 && w == hold) begin
        check("held_reads_le4", int'(issued <= 4), 1);
        ready_mode = saved;
      end
    end
    check("done_seen", int'(done_cyc >= 0), 1);
    check("words_left", exp_data.size(), 0);
    check("reads_left", exp_addr.size(), 0);
    if (n == 0) check("busy_on_zero", int'(busy), 0);
    if (timing) begin
      if (n > 0) begin
        check("first_rden_cycle", first_rden - c0, 1);
        check("first_valid_cycle", first_valid - c0, 3);
        check("done_cycle", done_cyc - c0, n + 3);
      end else begin
        check("done_cycle_zero", done_cyc - c0, 1);
      end
    end
    @(negedge clock);
    check("done_one_cycle", int'(done), 0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rden"}, int'(rden), 0);
    check({tag, "_rdaddress"}, int'(rdaddress), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
  endtask

  initial begin
    int c0;
    int n;
    int md;
    int br;
    reset_n = 1'b0; start = 1'b0; base = '0; count = '0; out_ready = 1'b1;
`ifdef MEM_STREAM_READER_BITREV_EN
    bitrev = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    ready_mode = 0;
    run_burst(5, 4, 0, 1'b1, 0);
    run_burst(62, 4, 0, 1'b1, 0);
    run_burst(17, 0, 0, 1'b1, 0);
    run_burst(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 1'b1, 0);
    run_burst(3, 8, 0, 1'b0, 10);

    // Reset in the middle of a long burst, then a clean burst.
    ready_mode = 1;
    begin_burst(40, 40, 0, c0);
    repeat (6) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrun");
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    ready_mode = 0;
    run_burst(5, 4, 0, 1'b1, 0);

`ifdef MEM_STREAM_READER_BITREV_EN
    run_burst(0, 8, 1, 1'b1, 0);
`endif

    for (int t = 0; t < 14; t++) begin
      md = int'($urandom_range(0, 1));
      ready_mode = md;
      n = (t % 5 == 0) ? 0 : int'($urandom_range(1, DEPTH));
`ifdef MEM_STREAM_READER_BITREV_EN
      br = int'($urandom_range(0, 1));
`else
      br = 0;
`endif
      run_burst(int'($urandom_range(0, DEPTH - 1)), n, br, (md == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
